// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer and flag controller for an async FIFO.
// Only the registered gray write pointer crosses to the read domain.
module fifo_wr_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALMOST_FULL_TH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rptr_bin_sync_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  overflow_o
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH  = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AF_TH  = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] r_wptr_bin;
  logic [PW-1:0] r_wptr_gray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_wr_acc;
  logic [PW-1:0] w_wptr_bin_next;
  logic [PW-1:0] w_wptr_gray_next;
  logic [PW-1:0] w_level_next;

  // Acceptance uses the registered full flag, so a read advance seen this
  // cycle cannot admit a write until the flag has cleared.
  always_comb begin
    w_wr_acc         = wr_en_i & ~r_full;
    w_wptr_bin_next  = r_wptr_bin + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    w_wptr_gray_next = w_wptr_bin_next ^ (w_wptr_bin_next >> 1);
    w_level_next     = w_wptr_bin_next - rptr_bin_sync_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr_bin    <= '0;
      r_wptr_gray   <= '0;
      r_level       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wptr_bin    <= w_wptr_bin_next;
      r_wptr_gray   <= w_wptr_gray_next;
      r_level       <= w_level_next;
      r_full        <= (w_level_next == DEPTH);
      r_almost_full <= (w_level_next >= AF_TH);
      r_overflow    <= wr_en_i & r_full;
    end
  end

  assign mem_we_o      = w_wr_acc;
  assign mem_waddr_o   = r_wptr_bin[ADDR_WIDTH-1:0];
  assign wptr_gray_o   = r_wptr_gray;
  assign full_o        = r_full;
  assign almost_full_o = r_almost_full;
  assign wr_level_o    = r_level;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl: vector table plus wrap and async-reset sequences.
module tb_fifo_wr_ptr_ctrl;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW:0]   rptr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_TH(12)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_en_i        (wr_en),
    .rptr_bin_sync_i(rptr),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .wptr_gray_o    (wptr_gray),
    .full_o         (full),
    .almost_full_o  (almost_full),
    .wr_level_o     (wr_level),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr_en;
    logic [AW:0]   rptr;
    logic          we;      // before the edge
    logic [AW-1:0] waddr;   // before the edge
    logic [AW:0]   gray;    // after the edge
    logic          full;
    logic          af;
    logic [AW:0]   level;
    logic          ovf;
  } vec_t;

  localparam int unsigned NVEC = 19;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    wr_en = v.wr_en;
    rptr  = v.rptr;
    #1;
    check($sformatf("v%0d we", idx), 32'(mem_we), 32'(v.we));
    check($sformatf("v%0d waddr", idx), 32'(mem_waddr), 32'(v.waddr));
    @(posedge clk);
    #1;
    check($sformatf("v%0d gray", idx), 32'(wptr_gray), 32'(v.gray));
    check($sformatf("v%0d full", idx), 32'(full), 32'(v.full));
    check($sformatf("v%0d afull", idx), 32'(almost_full), 32'(v.af));
    check($sformatf("v%0d level", idx), 32'(wr_level), 32'(v.level));
    check($sformatf("v%0d ovf", idx), 32'(overflow), 32'(v.ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " waddr"}, 32'(mem_waddr), 0);
    check({tag, " gray"}, 32'(wptr_gray), 0);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " afull"}, 32'(almost_full), 0);
    check({tag, " level"}, 32'(wr_level), 0);
    check({tag, " ovf"}, 32'(overflow), 0);
  endtask

  logic [AW:0] gray_seq [16];
  logic [AW:0] prev_gray;

  initial begin
    // Hand-computed gray codes of 1..16.
    gray_seq = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'b11000};
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{wr_en: 1'b1, rptr: 5'd0, we: 1'b1, waddr: 4'(i),
                 gray: gray_seq[i], full: (i == 15), af: (i >= 11),
                 level: 5'(i + 1), ovf: 1'b0};
    end
    // Writes while full are rejected and pulse overflow.
    tbl[16] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    tbl[17] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    // Reader frees one slot.
    tbl[18] = '{1'b0, 5'd1, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0};

    rst   = 1'b1;
    wr_en = 1'b0;
    rptr  = '0;
    #12;
    check_all_zero("reset");
    check("reset we", 32'(mem_we), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) apply_vec(tbl[i], i);

    // Wrap: writer and reader advance together so level stays 0.
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    #1;
    rst   = 1'b0;
    prev_gray = '0;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      wr_en = 1'b1;
      rptr  = 5'(k + 1);
      @(posedge clk);
      #1;
      check($sformatf("wrap step%0d gray 1-bit", k), $countones(wptr_gray ^ prev_gray), 1);
      prev_gray = wptr_gray;
    end
    check("wrap pre gray", 32'(wptr_gray), 32'b10000);
    check("wrap pre level", 32'(wr_level), 0);
    @(negedge clk);
    rptr = 5'd0;
    #1;
    check("wrap waddr", 32'(mem_waddr), 15);
    check("wrap we", 32'(mem_we), 1);
    @(posedge clk);
    #1;
    check("wrap gray", 32'(wptr_gray), 0);
    check("wrap gray 1-bit", $countones(wptr_gray ^ prev_gray), 1);
    check("wrap waddr after", 32'(mem_waddr), 0);
    check("wrap level", 32'(wr_level), 0);

    // Async reset mid-burst at level 7.
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    #1;
    rst   = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      wr_en = 1'b1;
      rptr  = '0;
      @(posedge clk);
    end
    #1;
    check("burst level", 32'(wr_level), 7);
    check("burst gray", 32'(wptr_gray), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    wr_en = 1'b0;
    #1;
    check("async rst we", 32'(mem_we), 0);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b1;
    #1;
    check("resume waddr", 32'(mem_waddr), 0);
    check("resume we", 32'(mem_we), 1);
    @(posedge clk);
    #1;
    check("resume level", 32'(wr_level), 1);
    check("resume gray", 32'(wptr_gray), 1);
    check("resume waddr next", 32'(mem_waddr), 1);
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO. It consumes the binary read pointer produced by the gray-to-binary converter, which is fed by the 2-FF-synchronised read gray pointer. It maintains the binary and gray write pointers, drives the dual-port RAM write port, and generates full, almost-full, level and overflow status. Its registered gray write pointer is the only signal that crosses to the read domain.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_FULL_TH, 12, level at or above which almost_full_o asserts; legal range 1..DEPTH.

Ports:
clk_i  input  1  write-domain clock
rst_i  input  1  asynchronous active-high reset
wr_en_i  input  1  write request
rptr_bin_sync_i  input  ADDR_WIDTH+1  read pointer in binary, already synchronised and converted, write domain
mem_we_o  output  1  RAM write enable
mem_waddr_o  output  ADDR_WIDTH  RAM write address
wptr_gray_o  output  ADDR_WIDTH+1  registered gray write pointer, to the read-domain synchroniser
full_o  output  1  FIFO full
almost_full_o  output  1  level >= ALMOST_FULL_TH
wr_level_o  output  ADDR_WIDTH+1  words held, as seen from the write side
overflow_o  output  1  one-cycle pulse: write attempted while full

Behaviour:
- Reset (async, active-high, effective immediately): wptr_bin=0, wptr_gray_o=0, full_o=0, almost_full_o=0, wr_level_o=0, overflow_o=0.
- Accept: wr_acc = wr_en_i & ~full_o, combinational.
- mem_we_o = wr_acc, combinational.
- mem_waddr_o = wptr_bin[ADDR_WIDTH-1:0], taken from the register and therefore stable all cycle.
- wptr_bin_next = wptr_bin + wr_acc, modulo 2^(ADDR_WIDTH+1); it wraps from all-ones to 0.
- wptr_gray_o is registered from wptr_bin_next ^ (wptr_bin_next >> 1). It updates on the same edge as wptr_bin. It never passes through combinational logic to the output, and it changes by at most one bit per cycle.
- level_next = (wptr_bin_next - rptr_bin_sync_i) mod 2^(ADDR_WIDTH+1); the result is always 0..DEPTH.
- wr_level_o is registered from level_next.
- full_o is registered from (level_next == DEPTH).
- almost_full_o is registered from (level_next >= ALMOST_FULL_TH).
- Latency: write accepted at edge N -> wptr_gray_o, wr_level_o and flags updated after edge N, visible in cycle N+1. The DEPTH-th accepted write asserts full_o in the next cycle.
- Full is conservative: rptr_bin_sync_i lags the true read pointer, so full_o may stay high after the reader frees space. It clears on the first edge after rptr_bin_sync_i advances. No write is ever accepted into an occupied slot.
- Write while full: wr_en_i=1 & full_o=1 -> mem_we_o=0, pointers unchanged, overflow_o=1 for exactly the next cycle (registered). Each rejected cycle produces its own pulse.
- Simultaneous events:
  - Write attempt in the same cycle that rptr_bin_sync_i advances while full_o=1: the write is rejected, because full_o is the registered value. full_o clears next cycle.
  - Write and read advance in the same cycle when not full: the level is unchanged.
- rptr_bin_sync_i is sampled every cycle with no qualification. The upstream synchroniser guarantees it is glitch-free within the write domain.
- No state machine; all state lives in the wptr_bin, wptr_gray, level, flag and overflow registers.

Test Plan:
1. ADDR_WIDTH=4, reset, rptr_bin_sync_i=0, wr_en_i=1 for 16 cycles -> mem_waddr_o runs 0..15 with mem_we_o=1; after the 16th edge full_o=1, wr_level_o=16, wptr_gray_o=5'b11000.
2. Continuing from 1, wr_en_i=1 for two more cycles -> mem_we_o=0, wptr_gray_o holds 5'b11000, overflow_o high for two cycles then 0.
3. Continuing from 2, wr_en_i=0, rptr_bin_sync_i 0->1 -> one edge later full_o=0, wr_level_o=15, almost_full_o stays 1 (TH=12).
4. Wrap: preload by writing until wptr_bin=31 with rptr_bin_sync_i tracking (level 0), then write once -> wptr_gray_o goes 5'b10000->5'b00000 (single-bit change), mem_waddr_o=15 on that write, and wptr_bin then reads 0.
5. From empty with rptr=0 and TH=12: 11 writes -> almost_full_o=0; 12th write -> almost_full_o=1 next cycle, full_o=0.
6. rst_i asserted asynchronously mid-burst at level 7 -> all outputs 0 before the next clk_i edge; after release, writing resumes at mem_waddr_o=0.
